// File: rtl/mouse_cursor_overlay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mouse_cursor_overlay                                              |
// | Brief  : 2-stage arrow-cursor renderer with a frame-synchronous position   |
// |          update. Optional macro CURSOR_CLAMP_EN keeps the cursor on screen. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mouse_cursor_overlay #(
  parameter int H_BITS   = 10,
  parameter int V_BITS   = 10,
  parameter int CUR_W    = 8,
  parameter int CUR_H    = 11,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              cursor_en,
  input  logic              mouse_valid,
  input  logic [H_BITS-1:0] mouse_x,
  input  logic [V_BITS-1:0] mouse_y,
  output logic              mouse_ready,
  input  logic              pix_valid,
  input  logic [H_BITS-1:0] pix_x,
  input  logic [V_BITS-1:0] pix_y,
  output logic              out_valid,
  output logic              cursor_on
);

  localparam int DXW = (CUR_W > 1) ? $clog2(CUR_W) : 1;
  localparam int DYW = (CUR_H > 1) ? $clog2(CUR_H) : 1;
  localparam logic [H_BITS-1:0] CUR_W_X = H_BITS'(CUR_W);
  localparam logic [V_BITS-1:0] CUR_H_Y = V_BITS'(CUR_H);

  // The tail length is hard-wired to three rows, and the clamp limits must be reachable.
  if (CUR_W < 4 || CUR_H != CUR_W + 3 || H_ACTIVE < CUR_W || V_ACTIVE < CUR_H) begin : g_bad_params
    $error("mouse_cursor_overlay: illegal cursor geometry parameters");
  end

  logic              pend_full;
  logic [H_BITS-1:0] pend_x;
  logic [V_BITS-1:0] pend_y;
  logic [H_BITS-1:0] act_x;
  logic [V_BITS-1:0] act_y;
  logic [H_BITS-1:0] next_act_x;
  logic [V_BITS-1:0] next_act_y;
  logic              accept;

  assign mouse_ready = ~pend_full;
  assign accept      = mouse_valid & ~pend_full;

`ifdef CURSOR_CLAMP_EN
  localparam logic [H_BITS-1:0] X_MAX = H_BITS'(H_ACTIVE - CUR_W);
  localparam logic [V_BITS-1:0] Y_MAX = V_BITS'(V_ACTIVE - CUR_H);
  assign next_act_x = (pend_x > X_MAX) ? X_MAX : pend_x;
  assign next_act_y = (pend_y > Y_MAX) ? Y_MAX : pend_y;
`else
  assign next_act_x = pend_x;
  assign next_act_y = pend_y;
`endif

  // Accept is blocked while full, so a frame_start transfer never races an overwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      act_x     <= '0;
      act_y     <= '0;
    end else if (frame_start && pend_full) begin
      act_x     <= next_act_x;
      act_y     <= next_act_y;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend_x    <= mouse_x;
      pend_y    <= mouse_y;
      pend_full <= 1'b1;
    end
  end

  logic [H_BITS-1:0] dx;
  logic [V_BITS-1:0] dy;
  logic              in_win;

  assign dx     = pix_x - act_x;
  assign dy     = pix_y - act_y;
  assign in_win = cursor_en && (pix_x >= act_x) && (pix_y >= act_y) &&
                  (dx < CUR_W_X) && (dy < CUR_H_Y);

  logic           s1_valid;
  logic           s1_in_win;
  logic [DXW-1:0] s1_dx;
  logic [DYW-1:0] s1_dy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_in_win <= 1'b0;
      s1_dx     <= '0;
      s1_dy     <= '0;
    end else begin
      s1_valid  <= pix_valid;
      s1_in_win <= in_win;
      s1_dx     <= dx[DXW-1:0];
      s1_dy     <= dy[DYW-1:0];
    end
  end

  // Triangle rows light columns 0..dy; tail rows light columns with dx+dy < CUR_W+3.
  logic shape_bit;

  always_comb begin
    shape_bit = 1'b0;
    if (int'(s1_dy) < CUR_W) begin
      shape_bit = (int'(s1_dx) <= int'(s1_dy));
    end else begin
      shape_bit = ((int'(s1_dx) + int'(s1_dy)) < (CUR_W + 3));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      cursor_on <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      cursor_on <= s1_valid & s1_in_win & shape_bit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mouse_cursor_overlay.sv
`default_nettype none
// Directed bench for mouse_cursor_overlay: handshake, shape, latency, race, reset and edge cases.
module tb_mouse_cursor_overlay;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       cursor_en;
  logic       mouse_valid;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic       mouse_ready;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       out_valid;
  logic       cursor_on;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mouse_cursor_overlay dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .cursor_en   (cursor_en),
    .mouse_valid (mouse_valid),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .mouse_ready (mouse_ready),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .out_valid   (out_valid),
    .cursor_on   (cursor_on)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arrow: 8 wide, 8 triangle rows then masks 0x07, 0x03, 0x01.
  function automatic logic model(input int px, input int py, input int ax, input int ay,
                                 input logic en);
    int dxi, dyi, m;
    if (!en || px < ax || py < ay) return 1'b0;
    dxi = px - ax;
    dyi = py - ay;
    if (dxi >= 8 || dyi >= 11) return 1'b0;
    if (dyi < 8) m = (1 << (dyi + 1)) - 1;
    else         m = (1 << (3 - (dyi - 8))) - 1;
    return logic'((m >> dxi) & 1);
  endfunction

  task automatic probe(input string tag, input int x, input int y, input logic en,
                       input logic exp);
    pix_valid = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    cursor_en = en;
    tick();
    pix_valid = 1'b0;
    tick();
    check({tag, ".ov"}, out_valid, 1'b1);
    check(tag, cursor_on, exp);
  endtask

  // Back-to-back pixels along one row; output for pixel i appears after the edge of pixel i+1.
  task automatic scan(input string tag, input int y, input int x0, input int n,
                      input int ax, input int ay, input logic en);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        pix_valid = 1'b1;
        pix_x     = 10'(x0 + i);
        pix_y     = 10'(y);
      end else begin
        pix_valid = 1'b0;
      end
      cursor_en = en;
      tick();
      if (i >= 1)
        check($sformatf("%s y%0d x%0d", tag, y, x0 + i - 1), cursor_on,
              model(x0 + i - 1, y, ax, ay, en));
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; cursor_en = 1'b1; mouse_valid = 1'b0;
    mouse_x = '0; mouse_y = '0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    tick();
    check("rst.ov", out_valid, 1'b0);
    check("rst.co", cursor_on, 1'b0);
    check("rst.ready", mouse_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // Handshake: accept (100,50), hold off (7,7), old (0,0) position until frame_start.
    mouse_valid = 1'b1; mouse_x = 10'd100; mouse_y = 10'd50;
    tick();
    check("hs.ready_low", mouse_ready, 1'b0);
    mouse_x = 10'd7; mouse_y = 10'd7;
    tick();
    check("hs.ready_held", mouse_ready, 1'b0);
    probe("hs.origin_00", 0, 0, 1'b1, 1'b1);
    probe("hs.origin_10", 1, 0, 1'b1, 1'b0);
    probe("hs.origin_35", 3, 5, 1'b1, 1'b1);
    probe("hs.new_not_live", 100, 50, 1'b1, 1'b0);
    check("hs.ready_pre_fs", mouse_ready, 1'b0);
    pulse_frame();
    mouse_valid = 1'b0;
    check("hs.ready_after_fs", mouse_ready, 1'b1);
    pulse_frame();
    probe("hs.live_100_50", 100, 50, 1'b1, 1'b1);
    probe("hs.no_77", 7, 7, 1'b1, 1'b0);

    // Shape at (100,50).
    for (int y = 50; y <= 61; y++) scan("shape", y, 96, 16, 100, 50, 1'b1);
    probe("shape.r57c107", 107, 57, 1'b1, 1'b1);
    probe("shape.r57c108", 108, 57, 1'b1, 1'b0);
    probe("shape.r58c102", 102, 58, 1'b1, 1'b1);
    probe("shape.r58c103", 103, 58, 1'b1, 1'b0);
    probe("shape.r59c101", 101, 59, 1'b1, 1'b1);
    probe("shape.r59c102", 102, 59, 1'b1, 1'b0);
    probe("shape.r60c100", 100, 60, 1'b1, 1'b1);
    probe("shape.r60c101", 101, 60, 1'b1, 1'b0);
    probe("shape.r61c100", 100, 61, 1'b1, 1'b0);

    // Latency and bubbles: valid 1,0,1,1.
    cursor_en = 1'b1;
    pix_valid = 1'b1; pix_x = 10'd100; pix_y = 10'd50;
    tick();
    check("lat.early_ov", out_valid, 1'b0);
    pix_valid = 1'b0;
    tick();
    check("lat.p0_ov", out_valid, 1'b1);
    check("lat.p0_co", cursor_on, 1'b1);
    pix_valid = 1'b1; pix_x = 10'd105; pix_y = 10'd50;
    tick();
    check("lat.p1_ov", out_valid, 1'b0);
    check("lat.p1_co", cursor_on, 1'b0);
    pix_x = 10'd104; pix_y = 10'd57;
    tick();
    check("lat.p2_ov", out_valid, 1'b1);
    check("lat.p2_co", cursor_on, 1'b0);
    pix_valid = 1'b0;
    tick();
    check("lat.p3_ov", out_valid, 1'b1);
    check("lat.p3_co", cursor_on, 1'b1);
    tick();
    check("lat.drain_ov", out_valid, 1'b0);
    check("lat.drain_co", cursor_on, 1'b0);

    // Race: accept coincides with frame_start; no bypass.
    mouse_valid = 1'b1; mouse_x = 10'd200; mouse_y = 10'd100;
    frame_start = 1'b1;
    tick();
    mouse_valid = 1'b0; frame_start = 1'b0;
    check("race.accepted", mouse_ready, 1'b0);
    probe("race.old_live", 100, 50, 1'b1, 1'b1);
    probe("race.new_idle", 200, 100, 1'b1, 1'b0);
    pulse_frame();
    probe("race.new_live", 200, 100, 1'b1, 1'b1);
    probe("race.old_gone", 100, 50, 1'b1, 1'b0);

    // Asynchronous reset mid-stream.
    mouse_valid = 1'b1; mouse_x = 10'd300; mouse_y = 10'd300;
    pix_valid = 1'b1; pix_x = 10'd200; pix_y = 10'd100; cursor_en = 1'b1;
    tick();
    mouse_valid = 1'b0;
    check("arst.pre_busy", mouse_ready, 1'b0);
    tick();
    check("arst.pre_on", cursor_on, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("arst.ov", out_valid, 1'b0);
    check("arst.co", cursor_on, 1'b0);
    check("arst.ready", mouse_ready, 1'b1);
    pix_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("arst.flush1", out_valid, 1'b0);
    tick();
    check("arst.flush2", out_valid, 1'b0);
    probe("arst.origin", 0, 0, 1'b1, 1'b1);
    probe("arst.old_gone", 200, 100, 1'b1, 1'b0);
    pulse_frame();
    probe("arst.pend_dropped", 0, 0, 1'b1, 1'b1);

    // Edge of screen at (636,478).
    mouse_valid = 1'b1; mouse_x = 10'd636; mouse_y = 10'd478;
    tick();
    mouse_valid = 1'b0;
    pulse_frame();
`ifdef CURSOR_CLAMP_EN
    for (int y = 469; y <= 479; y++) scan("edge", y, 628, 12, 632, 469, 1'b1);
    probe("edge.clamp_origin", 632, 469, 1'b1, 1'b1);
    probe("edge.clamp_r478c633", 633, 478, 1'b1, 1'b1);
    probe("edge.clamp_r478c634", 634, 478, 1'b1, 1'b0);
    probe("edge.clamp_r476c639", 639, 476, 1'b1, 1'b1);
`else
    for (int y = 476; y <= 479; y++) scan("edge", y, 628, 12, 636, 478, 1'b1);
    for (int y = 0; y <= 1; y++) scan("edge.wrap", y, 0, 8, 636, 478, 1'b1);
    probe("edge.r478c636", 636, 478, 1'b1, 1'b1);
    probe("edge.r478c637", 637, 478, 1'b1, 1'b0);
    probe("edge.r479c637", 637, 479, 1'b1, 1'b1);
    probe("edge.r479c638", 638, 479, 1'b1, 1'b0);
    probe("edge.r479c0", 0, 479, 1'b1, 1'b0);
    probe("edge.r0c636", 636, 0, 1'b1, 1'b0);
`endif
    probe("en0.r478c636", 636, 478, 1'b0, 1'b0);
    probe("en0.r479c637", 637, 479, 1'b0, 1'b0);
    scan("en0", 479, 628, 12, 636, 478, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
